// File: rtl/avfcl_pkg.sv
// rtl/avfcl_pkg.sv - shared vop types, lane count and packed-word struct for the AVF trace path
package avfcl_pkg;

    typedef logic [3:0] vop_t;

    localparam vop_t VOP_NOP      = 4'd9;
    localparam int   NUM_LANES    = 2;
    localparam int   PACK_NIBBLES = 8;

    typedef struct packed {
        logic [4*PACK_NIBBLES-1:0]     data;
        logic [$clog2(PACK_NIBBLES):0] count;
    } vop_word_t;

    typedef enum logic {
        S_RUN,
        S_FLUSH_WAIT
    } packer_state_t;

endpackage

// File: rtl/vop_stream_packer_if.sv
// rtl/vop_stream_packer_if.sv - vop lane input and packed-word output handshake bundle
interface vop_stream_packer_if
    import avfcl_pkg::*;
#(
    parameter int WORD_NIBBLES = PACK_NIBBLES
);
    logic                            stall;
    logic [NUM_LANES-1:0]            in_valid;
    vop_t [NUM_LANES-1:0]            vops;
    logic                            flush;
    logic                            in_ready;
    logic                            out_valid;
    logic [4*WORD_NIBBLES-1:0]       out_data;
    logic [$clog2(WORD_NIBBLES):0]   out_count;
    logic                            out_ready;

    modport master (
        output stall, in_valid, vops, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  stall, in_valid, vops, flush, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/vop_word_fifo.sv
// rtl/vop_word_fifo.sv - completed-word FIFO with dual push, single pop and registered head
module vop_word_fifo
    import avfcl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push0,
    input  logic                       push1,
    input  vop_word_t                  data0,
    input  vop_word_t                  data1,
    input  logic                       pop,
    output logic                       head_valid,
    output vop_word_t                  head,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PW = $clog2(DEPTH);

    vop_word_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_n;
    logic [PW:0]     occ_after_pop;
    logic [PW:0]     occ_n;
    vop_word_t       head_n;

    // push1 is only ever raised together with push0, so it lands one slot behind
    always_comb begin
        rd_ptr_n      = rd_ptr + PW'(pop);
        occ_after_pop = occupancy - (PW+1)'(pop);
        occ_n         = occ_after_pop + (PW+1)'(push0) + (PW+1)'(push1);
        head_n        = '0;
        if (occ_after_pop != '0) begin
            head_n = mem[rd_ptr_n];
        end else if (push0) begin
            head_n = data0;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            mem[wr_ptr] <= data0;
        end
        if (push1) begin
            mem[wr_ptr + PW'(1)] <= data1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr     <= rd_ptr_n;
            occupancy  <= occ_n;
            head_valid <= (occ_n != '0);
            head       <= head_n;
        end
    end
endmodule

// File: rtl/vop_stream_packer.sv
// rtl/vop_stream_packer.sv - packs accepted two-lane vops in program order into trace words
module vop_stream_packer
    import avfcl_pkg::*;
#(
    parameter int WORD_NIBBLES = PACK_NIBBLES,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    vop_stream_packer_if.slave bus
);
    localparam int FW = $clog2(WORD_NIBBLES);
    localparam int CW = FW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [FW-1:0] FILL_LAST     = FW'(WORD_NIBBLES - 1);
    localparam logic [PW:0]   OCC_FULL      = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   OCC_READY_MAX = (PW+1)'(FIFO_DEPTH - 2);

    packer_state_t              state, state_n;
    vop_t [WORD_NIBBLES-1:0]    acc, acc_n;
    logic [FW-1:0]              fill, fill_n;
    logic [PW:0]                occ;
    logic                       accept;
    logic                       do_flush;
    logic                       push0, push1;
    vop_word_t                  word0, word1;
    vop_word_t                  head;

    // two free entries cover a completed word plus a flushed remainder in one cycle
    assign bus.in_ready = (state == S_RUN) && (occ <= OCC_READY_MAX);
    assign accept       = bus.in_ready & ~bus.stall;

    always_comb begin
        acc_n    = acc;
        fill_n   = fill;
        state_n  = state;
        do_flush = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        word0    = '0;
        word1    = '0;

        for (int l = 0; l < NUM_LANES; l++) begin
            if (accept && bus.in_valid[l]) begin
                acc_n[fill_n] = bus.vops[l];
                if (fill_n == FILL_LAST) begin
                    push0                            = 1'b1;
                    word0.data[4*WORD_NIBBLES-1:0]   = acc_n;
                    word0.count[CW-1:0]              = CW'(WORD_NIBBLES);
                    acc_n                            = '0;
                    fill_n                           = '0;
                end else begin
                    fill_n = fill_n + FW'(1);
                end
            end
        end

        case (state)
            S_RUN: begin
                if (bus.flush) begin
                    if (accept) begin
                        do_flush = 1'b1;
                    end else begin
                        state_n = S_FLUSH_WAIT;
                    end
                end
            end
            S_FLUSH_WAIT: begin
                if (fill == '0) begin
                    state_n = S_RUN;
                end else if (occ < OCC_FULL) begin
                    do_flush = 1'b1;
                    state_n  = S_RUN;
                end
            end
            default: state_n = S_RUN;
        endcase

        if (do_flush && (fill_n != '0)) begin
            if (push0) begin
                push1                            = 1'b1;
                word1.data[4*WORD_NIBBLES-1:0]   = acc_n;
                word1.count[CW-1:0]              = {1'b0, fill_n};
            end else begin
                push0                            = 1'b1;
                word0.data[4*WORD_NIBBLES-1:0]   = acc_n;
                word0.count[CW-1:0]              = {1'b0, fill_n};
            end
            acc_n  = '0;
            fill_n = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            acc   <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            fill  <= fill_n;
        end
    end

    vop_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push0      (push0),
        .push1      (push1),
        .data0      (word0),
        .data1      (word1),
        .pop        (bus.out_valid & bus.out_ready),
        .head_valid (bus.out_valid),
        .head       (head),
        .occupancy  (occ)
    );

    assign bus.out_data  = head.data[4*WORD_NIBBLES-1:0];
    assign bus.out_count = head.count[CW-1:0];
endmodule

// File: tb/tb_vop_stream_packer.sv
// tb/tb_vop_stream_packer.sv - directed self-checking bench for vop_stream_packer
module tb_vop_stream_packer;
    import avfcl_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    vop_stream_packer_if #(.WORD_NIBBLES(8)) bus ();

    vop_stream_packer #(
        .WORD_NIBBLES (8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] iv, input logic [3:0] v0, input logic [3:0] v1,
                         input logic fl, input logic st);
        bus.in_valid = iv;
        bus.vops[0]  = v0;
        bus.vops[1]  = v1;
        bus.flush    = fl;
        bus.stall    = st;
    endtask

    task automatic idle();
        drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] data, input logic [3:0] count);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_data"},  64'(bus.out_data),  64'(data));
        check({tag, "_count"}, 64'(bus.out_count), 64'(count));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        idle();

        cyc();
        cyc();
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data",  64'(bus.out_data),  64'(0));
        check("rst_count", 64'(bus.out_count), 64'(0));
        check("rst_ready", 64'(bus.in_ready),  64'(1));
        reset = 1'b0;
        cyc();

        drive(2'b11, 4'h0, 4'h1, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h2, 4'h3, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h4, 4'h5, 1'b0, 1'b0); cyc();
        check("fill_no_early", 64'(bus.out_valid), 64'(0));
        check("fill_ready",    64'(bus.in_ready),  64'(1));
        drive(2'b11, 4'h6, 4'h7, 1'b0, 1'b0); cyc();
        idle();
        expect_word("fill", 32'h76543210, 4'd8);
        cyc();
        check("fill_popped", 64'(bus.out_valid), 64'(0));

        drive(2'b11, 4'h1, 4'h1, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h1, 4'h1, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h1, 4'h1, 1'b0, 1'b0); cyc();
        drive(2'b01, 4'h1, 4'h0, 1'b0, 1'b0); cyc();
        check("wrap_no_early", 64'(bus.out_valid), 64'(0));
        drive(2'b11, 4'h2, 4'h3, 1'b1, 1'b0); cyc();
        idle();
        expect_word("wrap_first", 32'h21111111, 4'd8);
        cyc();
        expect_word("wrap_second", 32'h00000003, 4'd1);
        cyc();
        check("wrap_empty", 64'(bus.out_valid), 64'(0));

        drive(2'b10, 4'h0, 4'hA, 1'b0, 1'b0); cyc();
        drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b0); cyc();
        drive(2'b11, VOP_NOP, VOP_NOP, 1'b0, 1'b1);
        check("gap_stall_ready", 64'(bus.in_ready), 64'(1));
        cyc();
        drive(2'b01, 4'hB, 4'h0, 1'b0, 1'b0); cyc();
        drive(2'b00, 4'h0, 4'h0, 1'b1, 1'b0); cyc();
        idle();
        expect_word("gap", 32'h000000BA, 4'd2);
        cyc();
        check("gap_empty", 64'(bus.out_valid), 64'(0));

        drive(2'b00, 4'h0, 4'h0, 1'b1, 1'b0); cyc();
        idle();
        check("eflush_valid", 64'(bus.out_valid), 64'(0));
        check("eflush_ready", 64'(bus.in_ready),  64'(1));
        cyc();
        check("eflush_valid2", 64'(bus.out_valid), 64'(0));

        bus.out_ready = 1'b0;
        drive(2'b01, 4'h0, 4'h0, 1'b0, 1'b0); cyc();
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("bp_ready_%0d", k), 64'(bus.in_ready), 64'(1));
            drive(2'b11, 4'(2*k-1), 4'(2*k), 1'b0, 1'b0);
            cyc();
        end
        idle();
        check("bp_ready_low", 64'(bus.in_ready), 64'(0));
        expect_word("bp_head", 32'h76543210, 4'd8);
        drive(2'b11, 4'hF, 4'hF, 1'b1, 1'b0); cyc();
        idle();
        check("bp_flush_wait_ready", 64'(bus.in_ready), 64'(0));
        cyc();
        check("bp_full_ready", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        cyc();
        expect_word("bp_w1", 32'hFEDCBA98, 4'd8);
        cyc();
        expect_word("bp_w2", 32'h76543210, 4'd8);
        cyc();
        expect_word("bp_w3", 32'h00000008, 4'd1);
        cyc();
        check("bp_drained",   64'(bus.out_valid), 64'(0));
        check("bp_ready_end", 64'(bus.in_ready),  64'(1));

        bus.out_ready = 1'b0;
        drive(2'b11, 4'h1, 4'h2, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h3, 4'h4, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h5, 4'h6, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h7, 4'h8, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'h9, 4'hA, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'hB, 4'hC, 1'b0, 1'b0); cyc();
        drive(2'b01, 4'hD, 4'h0, 1'b0, 1'b0); cyc();
        idle();
        expect_word("mid_head", 32'h87654321, 4'd8);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_data",  64'(bus.out_data),  64'(0));
        check("mid_rst_count", 64'(bus.out_count), 64'(0));
        check("mid_rst_ready", 64'(bus.in_ready),  64'(1));
        cyc();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b11, 4'h8, 4'h9, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'hA, 4'hB, 1'b0, 1'b0); cyc();
        drive(2'b11, 4'hC, 4'hD, 1'b0, 1'b0); cyc();
        check("mid_no_early", 64'(bus.out_valid), 64'(0));
        drive(2'b11, 4'hE, 4'hF, 1'b0, 1'b0); cyc();
        idle();
        expect_word("mid_after", 32'hFEDCBA98, 4'd8);
        cyc();
        check("mid_empty", 64'(bus.out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
